ps2_kbd_decoder: RTL and testbench

- Downstream consumer of the PS2 keyboard host controller's RX FIFO. Parses raw scan-code set 2 bytes into single key events: code, extended flag, break flag.
- Filters protocol reply bytes out of the event stream.
- Tracks Caps/Num/Scroll lock state and drives the keyboard LEDs by issuing the 2-byte 0xED command back through the host controller's command interface.
- Events go to the CPU-side register block over a valid/ready handshake.

---
 rtl/ps2_kbd_decoder.sv | 176 +++++++++++++++++
 tb/tb_ps2_kbd_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_decoder.sv
// PS/2 scan-code set 2 decoder: turns RX FIFO bytes into single key events and
// keeps the keyboard lock LEDs in sync by issuing ED <mask> through the host.
module ps2_kbd_decoder #(
  parameter bit AUTO_LED = 1'b1
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic [7:0] kbd_rdata_i,
  input  logic       kbd_rvalid_i,
  output logic       kbd_rdeq_o,
  input  logic [7:0] kbd_stat_i,
  input  logic       kbd_bat_ok_i,
  output logic [7:0] kbd_wcmddata_o,
  output logic       kbd_enq_cmd1_o,
  output logic       kbd_enq_cmd2_o,
  output logic [7:0] evt_code_o,
  output logic       evt_ext_o,
  output logic       evt_break_o,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [2:0] lock_o,
  output logic [1:0] dbg_led_state_o,
  output logic       dbg_parse_idle_o
);

  // Handshakes: an RX byte moves when kbd_rvalid_i && kbd_rdeq_o; an event moves
  // when evt_valid_o && evt_ready_i, and its payload is stable while valid && !ready.
  typedef enum logic [1:0] {L_IDLE = 2'd0, L_WAIT = 2'd1, L_CMD = 2'd2, L_DATA = 2'd3} led_state_e;

  led_state_e led_state_q;
  logic       ext_q, ext_d, brk_q, brk_d, e1brk_q, e1brk_d;
  logic [1:0] e1cnt_q, e1cnt_d;
  logic [7:0] evt_code_q;
  logic       evt_ext_q, evt_brk_q, evt_valid_q;
  logic [2:0] lock_q, lock_d, tog;
  logic       led_pending_q, led_req;
  logic [7:0] wcmd_q;
  logic       cmd1_q, cmd2_q;
  logic       rdeq, is_drop, emit, emit_ext, emit_brk;
  logic [7:0] emit_code;

  assign rdeq    = kbd_rvalid_i && (!evt_valid_q || evt_ready_i);
  assign is_drop = kbd_rdata_i inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    e1cnt_d   = e1cnt_q;
    e1brk_d   = e1brk_q;
    emit      = 1'b0;
    emit_code = kbd_rdata_i;
    emit_ext  = ext_q;
    emit_brk  = brk_q;
    if (rdeq && !is_drop) begin
      if (kbd_rdata_i == 8'hE0) begin
        ext_d = 1'b1;
      end else if (kbd_rdata_i == 8'hF0) begin
        if (e1cnt_q != 2'd0) e1brk_d = 1'b1;
        else                 brk_d   = 1'b1;
      end else if (kbd_rdata_i == 8'hE1) begin
        e1cnt_d = 2'd2;
        e1brk_d = 1'b0;
      end else if (e1cnt_q != 2'd0) begin
        // Pause is reported as one extended 0x77 make; its break half is swallowed.
        e1cnt_d = e1cnt_q - 2'd1;
        if (e1cnt_q == 2'd1) begin
          emit      = !e1brk_q;
          emit_code = 8'h77;
          emit_ext  = 1'b1;
          emit_brk  = 1'b0;
          ext_d     = 1'b0;
          brk_d     = 1'b0;
          e1brk_d   = 1'b0;
        end
      end else if (ext_q && (kbd_rdata_i == 8'h12 || kbd_rdata_i == 8'h59)) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        emit  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_comb begin
    tog = 3'b000;
    if (AUTO_LED && emit && !emit_brk && !emit_ext) begin
      case (emit_code)
        8'h58:   tog = 3'b100;
        8'h77:   tog = 3'b010;
        8'h7E:   tog = 3'b001;
        default: tog = 3'b000;
      endcase
    end
    lock_d  = lock_q ^ tog;
    led_req = (|tog) || (AUTO_LED && kbd_bat_ok_i);
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      e1cnt_q     <= 2'd0;
      e1brk_q     <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      lock_q      <= 3'b000;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      e1cnt_q <= e1cnt_d;
      e1brk_q <= e1brk_d;
      lock_q  <= lock_d;
      if (emit) begin
        evt_code_q  <= emit_code;
        evt_ext_q   <= emit_ext;
        evt_brk_q   <= emit_brk;
        evt_valid_q <= 1'b1;
      end else if (evt_valid_q && evt_ready_i) begin
        evt_code_q  <= 8'h00;
        evt_ext_q   <= 1'b0;
        evt_brk_q   <= 1'b0;
        evt_valid_q <= 1'b0;
      end
    end
  end

  // A request arriving in L_CMD wins over the clear, forcing one more ED sequence.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      led_state_q   <= L_IDLE;
      led_pending_q <= 1'b0;
      wcmd_q        <= 8'h00;
      cmd1_q        <= 1'b0;
      cmd2_q        <= 1'b0;
    end else begin
      cmd1_q <= 1'b0;
      cmd2_q <= 1'b0;
      if (led_req)                  led_pending_q <= 1'b1;
      else if (led_state_q == L_CMD) led_pending_q <= 1'b0;
      case (led_state_q)
        L_IDLE: if (led_pending_q) led_state_q <= L_WAIT;
        L_WAIT: begin
          if (kbd_stat_i != 8'h01) begin
            led_state_q <= L_CMD;
            wcmd_q      <= 8'hED;
            cmd2_q      <= 1'b1;
          end
        end
        L_CMD: begin
          led_state_q <= L_DATA;
          wcmd_q      <= {5'b00000, lock_q};
          cmd1_q      <= 1'b1;
        end
        L_DATA:  led_state_q <= L_IDLE;
        default: led_state_q <= L_IDLE;
      endcase
    end
  end

  assign kbd_rdeq_o       = rdeq;
  assign kbd_wcmddata_o   = wcmd_q;
  assign kbd_enq_cmd1_o   = cmd1_q;
  assign kbd_enq_cmd2_o   = cmd2_q;
  assign evt_code_o       = evt_code_q;
  assign evt_ext_o        = evt_ext_q;
  assign evt_break_o      = evt_brk_q;
  assign evt_valid_o      = evt_valid_q;
  assign lock_o           = lock_q;
  assign dbg_led_state_o  = led_state_q;
  assign dbg_parse_idle_o = !ext_q && !brk_q && !e1brk_q && (e1cnt_q == 2'd0);

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Bench for ps2_kbd_decoder: directed scenarios plus randomized byte streams,
// checked against a byte-level scan-code model with an expected-event queue.
module tb_ps2_kbd_decoder;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rdata = 8'h00, stat = 8'h00, rdata0 = 8'h00;
  logic       rvalid = 1'b0, bat = 1'b0, ready = 1'b1, rvalid0 = 1'b0;
  logic       rdeq, cmd1, cmd2, ext, brk, valid;
  logic [7:0] wcmd, code;
  logic [2:0] lock;
  logic [1:0] dbg_state;
  logic       dbg_idle;
  logic       rdeq0, cmd1_0, cmd2_0, ext0, brk0, valid0, dbg_idle0;
  logic [7:0] wcmd0, code0;
  logic [2:0] lock0;
  logic [1:0] dbg_state0;

  ps2_kbd_decoder #(.AUTO_LED(1'b1)) dut (
    .clk6x(clk6x), .resetn(resetn), .kbd_rdata_i(rdata), .kbd_rvalid_i(rvalid),
    .kbd_rdeq_o(rdeq), .kbd_stat_i(stat), .kbd_bat_ok_i(bat), .kbd_wcmddata_o(wcmd),
    .kbd_enq_cmd1_o(cmd1), .kbd_enq_cmd2_o(cmd2), .evt_code_o(code), .evt_ext_o(ext),
    .evt_break_o(brk), .evt_valid_o(valid), .evt_ready_i(ready), .lock_o(lock),
    .dbg_led_state_o(dbg_state), .dbg_parse_idle_o(dbg_idle));

  ps2_kbd_decoder #(.AUTO_LED(1'b0)) dut0 (
    .clk6x(clk6x), .resetn(resetn), .kbd_rdata_i(rdata0), .kbd_rvalid_i(rvalid0),
    .kbd_rdeq_o(rdeq0), .kbd_stat_i(8'h00), .kbd_bat_ok_i(bat), .kbd_wcmddata_o(wcmd0),
    .kbd_enq_cmd1_o(cmd1_0), .kbd_enq_cmd2_o(cmd2_0), .evt_code_o(code0), .evt_ext_o(ext0),
    .evt_break_o(brk0), .evt_valid_o(valid0), .evt_ready_i(1'b1), .lock_o(lock0),
    .dbg_led_state_o(dbg_state0), .dbg_parse_idle_o(dbg_idle0));

  // ---------------- clock ----------------
  always #10 clk6x = ~clk6x;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];       // {code, ext, brk}
  logic [8:0] cmd_log[$];     // {is_cmd2, byte}
  bit         mon_en = 1'b0;
  bit         m_ext, m_brk, m_e1brk;
  int         m_e1cnt;
  logic [2:0] lock_m = 3'b000, lock_at_cmd = 3'b000;
  bit         led_req_m = 1'b0, prev_cmd2 = 1'b0, prev_stat_busy = 1'b0, last_deq = 1'b0;
  int         deq_cnt = 0, acc_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: scan-code set 2 rules applied one dequeued byte at a time.
  task automatic model_byte(input logic [7:0] b);
    logic [9:0] ev;
    bit         fire;
    fire = 1'b0;
    ev   = '0;
    if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) return;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) begin
      if (m_e1cnt > 0) m_e1brk = 1'b1;
      else m_brk = 1'b1;
    end else if (b == 8'hE1) begin
      m_e1cnt = 2;
      m_e1brk = 1'b0;
    end else if (m_e1cnt > 0) begin
      m_e1cnt = m_e1cnt - 1;
      if (m_e1cnt == 0) begin
        if (!m_e1brk) begin fire = 1'b1; ev = {8'h77, 1'b1, 1'b0}; end
        m_ext = 1'b0; m_brk = 1'b0; m_e1brk = 1'b0;
      end
    end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      fire = 1'b1;
      ev = {b, m_ext, m_brk};
      m_ext = 1'b0; m_brk = 1'b0;
    end
    if (fire) begin
      exp_q.push_back(ev);
      if (ev[1:0] == 2'b00) begin
        if (ev[9:2] == 8'h58) begin lock_m ^= 3'b100; led_req_m = 1'b1; end
        if (ev[9:2] == 8'h77) begin lock_m ^= 3'b010; led_req_m = 1'b1; end
        if (ev[9:2] == 8'h7E) begin lock_m ^= 3'b001; led_req_m = 1'b1; end
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_e1brk = 1'b0; m_e1cnt = 0;
    lock_m = 3'b000; lock_at_cmd = 3'b000;
    led_req_m = 1'b0; prev_cmd2 = 1'b0; prev_stat_busy = 1'b0; last_deq = 1'b0;
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk6x) begin
    if (resetn && mon_en) begin
      chk("rdeq", rdeq, rvalid && (exp_q.size() == 0 || ready));
      chk("evt_valid", valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("evt_payload", {code, ext, brk}, exp_q[0]);
      chk("lock", lock, lock_m);
      chk("strobe_excl", cmd1 && cmd2, 1'b0);
      chk("cmd_seq", cmd1, prev_cmd2);
      if (cmd2) begin
        chk("cmd2_data", wcmd, 8'hED);
        chk("cmd_stat", prev_stat_busy, 1'b0);
        cmd_log.push_back({1'b1, wcmd});
        led_req_m   = 1'b0;
        lock_at_cmd = lock_m;
      end
      if (cmd1) begin
        chk("cmd1_data", wcmd, {5'b00000, lock_at_cmd});
        cmd_log.push_back({1'b0, wcmd});
      end
      prev_cmd2      = cmd2;
      prev_stat_busy = (stat == 8'h01);
      if (bat) led_req_m = 1'b1;
      if (exp_q.size() != 0 && ready) begin
        void'(exp_q.pop_front());
        acc_cnt++;
      end
      last_deq = rdeq;
      if (rdeq) begin
        deq_cnt++;
        model_byte(rdata);
      end
    end
    if (resetn && mon_en) begin
      chk("led0_strobe", {cmd1_0, cmd2_0}, 2'b00);
      chk("lock0", lock0, 3'b000);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk6x);
    #1;
  endtask

  // Called at posedge+1; presents one byte and returns at posedge+1 after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    rdata  = b;
    rvalid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk6x);
      if (rdeq) got = 1'b1;
      n++;
    end
    chk("deq_timeout", got, 1'b1);
    @(posedge clk6x);
    #1;
    rvalid = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (cmd_log.size() < n && k < 200) begin
      @(posedge clk6x);
      k++;
    end
    idle(10);
    chk("log_len", cmd_log.size(), n);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", valid, 1'b0);
    chk("rst_lock", lock, 3'b000);
    idle(2);
    resetn = 1'b1;
    idle(1);
  endtask

  logic [7:0] palette [0:23] = '{8'h1C, 8'h1B, 8'h23, 8'h58, 8'h77, 8'h7E, 8'h12, 8'h59,
                                 8'h75, 8'h6B, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h14,
                                 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hEE, 8'hFF, 8'h5A, 8'h29};

  // ---------------- stimulus ----------------
  initial begin
    int save_deq, save_acc, rr;
    logic [2:0] lk;
    model_reset();
    repeat (3) @(posedge clk6x);
    @(negedge clk6x);
    chk("rst_evt_valid", valid, 1'b0);
    chk("rst_evt", {code, ext, brk}, 10'h000);
    chk("rst_lock", lock, 3'b000);
    chk("rst_wcmd", wcmd, 8'h00);
    chk("rst_strobes", {cmd1, cmd2}, 2'b00);
    chk("rst_rdeq", rdeq, 1'b0);
    chk("rst_led_state", dbg_state, 2'd0);
    chk("rst_parse_idle", dbg_idle, 1'b1);
    @(posedge clk6x);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // make / break of 0x1C
    save_acc = acc_cnt;
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle(3);
    chk("t1_events", acc_cnt - save_acc, 2);

    // extended break, filtered replies, fake shift
    save_deq = deq_cnt;
    save_acc = acc_cnt;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hFA); send_byte(8'hAA); send_byte(8'hE0); send_byte(8'h12);
    idle(3);
    chk("t2_deq", deq_cnt - save_deq, 7);
    chk("t2_events", acc_cnt - save_acc, 1);
    chk("t2_parse_idle", dbg_idle, 1'b1);

    // pause key
    save_acc = acc_cnt;
    lk = lock;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    idle(3);
    chk("t3_events", acc_cnt - save_acc, 1);
    chk("t3_lock", lock, lk);
    chk("t3_parse_idle", dbg_idle, 1'b1);

    // backpressure
    ready = 1'b0;
    send_byte(8'h1C);
    rdata = 8'h2A;
    rvalid = 1'b1;
    idle(5);
    chk("t4_hold_code", code, 8'h1C);
    chk("t4_hold_valid", valid, 1'b1);
    ready = 1'b1;
    @(negedge clk6x);
    chk("t4_deq_on_accept", rdeq, 1'b1);
    @(posedge clk6x);
    #1;
    ready = 1'b0;
    rvalid = 1'b0;
    idle(3);
    chk("t4_second_code", code, 8'h2A);
    ready = 1'b1;
    idle(2);

    // caps toggle behind a busy host, plus a second toggle landing in L_CMD
    cmd_log.delete();
    stat = 8'h01;
    send_byte(8'h58);
    idle(10);
    chk("t5_no_strobe", cmd_log.size(), 0);
    chk("t5_lock", lock, 3'b100);
    stat = 8'h00;
    @(posedge clk6x);
    #1;
    send_byte(8'h58);
    wait_log(4);
    if (cmd_log.size() == 4) begin
      chk("t5_c0", cmd_log[0], {1'b1, 8'hED});
      chk("t5_c1", cmd_log[1], {1'b0, 8'h04});
      chk("t5_c2", cmd_log[2], {1'b1, 8'hED});
      chk("t5_c3", cmd_log[3], {1'b0, 8'h00});
    end

    // num lock on, then BAT resend
    cmd_log.delete();
    send_byte(8'h77);
    wait_log(2);
    chk("t6_lock", lock, 3'b010);
    cmd_log.delete();
    bat = 1'b1;
    idle(1);
    bat = 1'b0;
    wait_log(2);
    if (cmd_log.size() == 2) begin
      chk("t6_c0", cmd_log[0], {1'b1, 8'hED});
      chk("t6_c1", cmd_log[1], {1'b0, 8'h02});
    end
    chk("t6_lock_kept", lock, 3'b010);

    // reset in the middle of an E0 prefix
    send_byte(8'hE0);
    pulse_reset();
    save_acc = acc_cnt;
    send_byte(8'h1C);
    chk("t7_code", code, 8'h1C);
    chk("t7_ext", ext, 1'b0);
    idle(2);
    chk("t7_events", acc_cnt - save_acc, 1);

    // AUTO_LED=0 instance
    rdata0 = 8'h58;
    rvalid0 = 1'b1;
    @(negedge clk6x);
    chk("t8_deq0", rdeq0, 1'b1);
    @(posedge clk6x);
    #1;
    rvalid0 = 1'b0;
    @(negedge clk6x);
    chk("t8_evt0", {valid0, code0, ext0, brk0}, {1'b1, 8'h58, 2'b00});
    idle(10);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!rvalid || last_deq) begin
        rdata  = palette[$urandom_range(0, 23)];
        rvalid = ($urandom_range(0, 3) != 0);
      end
      ready = ($urandom_range(0, 3) != 0);
      rr = $urandom_range(0, 7);
      stat = (rr == 0) ? 8'h01 : (rr == 1) ? 8'hFA : (rr == 2) ? 8'hFE : 8'h00;
      bat = ($urandom_range(0, 99) == 0);
      idle(1);
    end
    rvalid = 1'b0;
    ready = 1'b1;
    stat = 8'h00;
    bat = 1'b0;
    idle(40);
    chk("end_led_req", led_req_m, 1'b0);
    chk("end_led_state", dbg_state, 2'd0);
    chk("end_exp_q", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
